// File: rtl/csa_pkg.sv
// ============================================================================
// Module  : csa_pkg
// Brief   : Shared types and sizing helpers for the carry-save stream accumulator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    function automatic int num_chunks(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int chunk_idx_w(input int acc_w, input int chunk);
        return ((acc_w / chunk) > 1) ? $clog2(acc_w / chunk) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_row.sv
// ============================================================================
// Module  : csa_row
// Brief   : Combinational WIDTH-bit 3:2 compressor row (sum + unshifted carry).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module csa_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = x[i] ^ y[i] ^ z[i];
        assign carry[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
    end

endmodule

`default_nettype wire

// File: rtl/csa_stream_accumulator.sv
// ============================================================================
// Module  : csa_stream_accumulator
// Brief   : Carry-save multi-operand accumulator with chunked final resolve.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHUNK     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf
);

    localparam int c_NUM_CHUNKS = num_chunks(ACC_WIDTH, CHUNK);
    localparam int c_IDX_W      = chunk_idx_w(ACC_WIDTH, CHUNK);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_s;
    logic [ACC_WIDTH-1:0]   r_c;
    logic                   r_d;
    logic [c_IDX_W-1:0]     r_idx;
    logic                   r_carry;
    logic [ACC_WIDTH-1:0]   r_sum;
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_last_chunk;
    logic                   w_handshake;
    logic [ACC_WIDTH-1:0]   w_a_ext;
    logic [ACC_WIDTH-1:0]   w_b_ext;
    logic [ACC_WIDTH-1:0]   w_s1;
    logic [ACC_WIDTH-1:0]   w_c1;
    logic [ACC_WIDTH-1:0]   w_s2;
    logic [ACC_WIDTH-1:0]   w_c2;
    logic [ACC_WIDTH-1:0]   w_c1_sh;
    logic [CHUNK-1:0]       w_s_chunk;
    logic [CHUNK-1:0]       w_c_chunk;
    logic [CHUNK:0]         w_chunk_add;

    assign in_ready     = (r_state == IDLE) || (r_state == ACCUM);
    assign out_valid    = (r_state == OUTPUT);
    assign out_sum      = r_sum;
    assign out_ovf      = r_ovf;
    assign w_accept     = in_valid && in_ready;
    assign w_handshake  = out_valid && out_ready;
    assign w_last_chunk = (r_idx == c_IDX_W'(c_NUM_CHUNKS - 1));

    assign w_a_ext = ACC_WIDTH'(in_a);
    assign w_b_ext = ACC_WIDTH'(in_b);
    assign w_c1_sh = {w_c1[ACC_WIDTH-2:0], 1'b0};

    csa_row #(.WIDTH(ACC_WIDTH)) u_row0 (
        .x     (r_s),
        .y     (r_c),
        .z     (w_a_ext),
        .sum   (w_s1),
        .carry (w_c1)
    );

    csa_row #(.WIDTH(ACC_WIDTH)) u_row1 (
        .x     (w_s1),
        .y     (w_c1_sh),
        .z     (w_b_ext),
        .sum   (w_s2),
        .carry (w_c2)
    );

    // One narrow ripple add per resolve cycle keeps the carry chain CHUNK bits long.
    assign w_s_chunk   = r_s[r_idx*CHUNK +: CHUNK];
    assign w_c_chunk   = r_c[r_idx*CHUNK +: CHUNK];
    assign w_chunk_add = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + (CHUNK+1)'(r_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                if (w_last_chunk) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (w_handshake) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_c     <= '0;
            r_d     <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_s <= w_s2;
                        r_c <= {w_c2[ACC_WIDTH-2:0], 1'b0};
                        // Carries leaving the top bit are weight 2^ACC_WIDTH: remember them for overflow.
                        r_d <= r_d | w_c1[ACC_WIDTH-1] | w_c2[ACC_WIDTH-1];
                    end
                end
                RESOLVE: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_chunk_add[CHUNK-1:0];
                    if (w_last_chunk) begin
                        r_ovf   <= r_d | w_chunk_add[CHUNK];
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_carry <= w_chunk_add[CHUNK];
                    end
                end
                OUTPUT: begin
                    if (w_handshake) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_d     <= 1'b0;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
// ============================================================================
// Module  : tb_csa_stream_accumulator
// Brief   : Directed scoreboard bench for csa_stream_accumulator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csa_stream_accumulator;
    import csa_pkg::*;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int CHUNK     = 4;
    localparam int NCH       = ACC_WIDTH / CHUNK;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a = '0;
    logic [WIDTH-1:0]     in_b = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ovf;

    int      errors = 0;
    int      checks = 0;
    exp_t    sb_q[$];
    longint  m_total = 0;

    csa_stream_accumulator #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .CHUNK     (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat, waits (bounded) for acceptance and updates the reference model.
    task automatic send_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
        int cnt = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (in_ready !== 1'b1 && cnt < 64) begin
            tick();
            cnt++;
        end
        if (cnt >= 64) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed=in_ready_low expected=in_ready_high");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_total  = m_total + longint'(a) + longint'(b);
        if (last) begin
            sb_q.push_back({m_total[ACC_WIDTH-1:0], (m_total >= (longint'(1) << ACC_WIDTH))});
            m_total = 0;
        end
    endtask

    // Called right after the last beat is accepted; checks latency, result, hold and handshake.
    task automatic collect(input string tag, input int hold);
        int   cnt = 0;
        exp_t e;
        while (out_valid !== 1'b1 && cnt < 64) begin
            tick();
            cnt++;
        end
        check({tag, ".latency"}, 64'(cnt), 64'(NCH));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".sum"}, 64'(out_sum), 64'(e.sum));
        check({tag, ".ovf"}, 64'(out_ovf), 64'(e.ovf));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, ".hold_sum"}, 64'(out_sum), 64'(e.sum));
            check({tag, ".hold_ovf"}, 64'(out_ovf), 64'(e.ovf));
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(out_valid), 64'(0));
        check({tag, ".post_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, ".post_sum_kept"}, 64'(out_sum), 64'(e.sum));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.out_sum", 64'(out_sum), 64'(0));
        check("reset.out_ovf", 64'(out_ovf), 64'(0));
        rst = 1'b0;
        tick();

        // Single beat 5+7
        send_beat(8'd5, 8'd7, 1'b1);
        collect("single", 0);
        tick();

        // Four beats of 255+255
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'hFF, i == 3);
        collect("four_ff", 0);
        tick();

        // 129 beats of 255+255: wraps and flags overflow
        for (int i = 0; i < 129; i++) send_beat(8'hFF, 8'hFF, i == 128);
        collect("ovf_129", 0);
        tick();

        // Gaps in in_valid during accumulation
        send_beat(8'd1, 8'd2, 1'b0);
        check("gap.in_ready0", 64'(in_ready), 64'(1));
        tick();
        check("gap.in_ready1", 64'(in_ready), 64'(1));
        tick();
        send_beat(8'd3, 8'd4, 1'b0);
        tick();
        check("gap.in_ready2", 64'(in_ready), 64'(1));
        send_beat(8'd10, 8'd0, 1'b1);
        collect("gaps", 0);
        tick();

        // Backpressure: consumer stalls 10 cycles
        send_beat(8'd100, 8'd200, 1'b1);
        collect("backpressure", 10);
        tick();

        // Reset while resolving chunk 2 discards the transaction
        send_beat(8'd7, 8'd9, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        m_total = 0;
        check("midreset.out_valid", 64'(out_valid), 64'(0));
        check("midreset.in_ready", 64'(in_ready), 64'(1));
        check("midreset.state", 64'(dut.r_state), 64'(IDLE));
        check("midreset.out_sum", 64'(out_sum), 64'(0));
        tick();
        send_beat(8'd1, 8'd2, 1'b1);
        collect("after_reset", 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
